// File: rtl/axis_pack.sv
// AXI-Stream byte packer: removes tkeep holes and null beats so every output beat
// is full except the LSB-contiguous last beat of each packet.
module axis_pack #(
  parameter int AXIS_DW    = 64,
  parameter int USER_W     = 1,
  parameter bit DROP_EMPTY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [AXIS_DW-1:0]     s_axis_tdata,
  input  logic [AXIS_DW/8-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [USER_W-1:0]      s_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXIS_DW-1:0]     m_axis_tdata,
  output logic [AXIS_DW/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [USER_W-1:0]      m_axis_tuser,
  output logic                   empty_drop,
  output logic                   busy
);

  localparam int AXIS_KW = AXIS_DW / 8;
  localparam int BUF_B   = 2 * AXIS_KW;
  localparam int CW      = $clog2(BUF_B + 1);
  localparam logic [CW-1:0] KW_C = CW'(AXIS_KW);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t            state;
  logic [7:0]        res_q [BUF_B];
  logic [7:0]        res_d [BUF_B];
  logic [7:0]        comp  [AXIS_KW];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     base;
  logic [CW-1:0]     kept;
  logic [CW-1:0]     run;
  logic [USER_W-1:0] user_q;
  logic              ready_en;
  logic              accept;
  logic              emit;

  // ready_en keeps s_axis_tready low until the first edge after reset release
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign emit          = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = ready_en && (state != FLUSH) && ((cnt <= KW_C) || emit);
  assign m_axis_tvalid = ((state == ACTIVE) && (cnt > KW_C)) ||
                         ((state == FLUSH) && ((cnt != '0) || !DROP_EMPTY));
  assign m_axis_tlast  = m_axis_tvalid && (state == FLUSH) && (cnt <= KW_C);
  assign m_axis_tuser  = user_q;
  assign busy          = (state != IDLE) || (cnt != '0);

  always_comb begin
    run = '0;
    for (int j = 0; j < AXIS_KW; j++) comp[j] = 8'h00;
    for (int i = 0; i < AXIS_KW; i++) begin
      if (s_axis_tkeep[i]) begin
        for (int j = 0; j < AXIS_KW; j++)
          if (run == CW'(j)) comp[j] = s_axis_tdata[8*i +: 8];
        run = run + 1'b1;
      end
    end
    kept = run;
  end

  // A zero-count FLUSH only exists for an empty packet kept as a single null byte
  always_comb begin
    for (int i = 0; i < AXIS_KW; i++) begin
      if (!m_axis_tvalid)
        m_axis_tkeep[i] = 1'b0;
      else if (cnt == '0)
        m_axis_tkeep[i] = (i == 0);
      else
        m_axis_tkeep[i] = (CW'(i) < cnt);
      m_axis_tdata[8*i +: 8] = (m_axis_tkeep[i] && (CW'(i) < cnt)) ? res_q[i] : 8'h00;
    end
  end

  always_comb begin
    base = emit ? (cnt - ((cnt > KW_C) ? KW_C : cnt)) : cnt;
    for (int k = 0; k < AXIS_KW; k++)
      res_d[k] = emit ? res_q[k + AXIS_KW] : res_q[k];
    for (int k = AXIS_KW; k < BUF_B; k++)
      res_d[k] = emit ? 8'h00 : res_q[k];
    if (accept) begin
      for (int k = 0; k < BUF_B; k++)
        for (int j = 0; j < AXIS_KW; j++)
          if ((CW'(j) < kept) && ((base + CW'(j)) == CW'(k))) res_d[k] = comp[j];
    end
    cnt_d = base + (accept ? kept : '0);
  end

  // A packet whose tlast arrives with nothing buffered had no kept bytes at all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      user_q     <= '0;
      ready_en   <= 1'b0;
      empty_drop <= 1'b0;
      for (int k = 0; k < BUF_B; k++) res_q[k] <= 8'h00;
    end else begin
      ready_en   <= 1'b1;
      empty_drop <= 1'b0;
      cnt        <= cnt_d;
      for (int k = 0; k < BUF_B; k++) res_q[k] <= res_d[k];
      case (state)
        IDLE: begin
          if (accept) begin
            user_q <= s_axis_tuser;
            if (!s_axis_tlast)
              state <= ACTIVE;
            else if (DROP_EMPTY && (cnt_d == '0))
              empty_drop <= 1'b1;
            else
              state <= FLUSH;
          end
        end
        ACTIVE: begin
          if (accept && s_axis_tlast) begin
            if (DROP_EMPTY && (cnt_d == '0)) begin
              empty_drop <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (emit && m_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pack.sv
// Randomised bench for axis_pack: packets are reduced to byte lists and re-chunked
// into the expected packed beats, then compared beat by beat with the DUT output.
module tb_axis_pack;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep;
  logic [UW-1:0] s_user;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic [UW-1:0] m_user;
  logic          empty_drop, busy;

  logic          k_s_valid, k_s_ready, k_s_last;
  logic [DW-1:0] k_s_data;
  logic [KW-1:0] k_s_keep;
  logic [UW-1:0] k_s_user;
  logic          k_m_valid, k_m_ready, k_m_last;
  logic [DW-1:0] k_m_data;
  logic [KW-1:0] k_m_keep;
  logic [UW-1:0] k_m_user;
  logic          k_empty_drop, k_busy;

  beat_t in_q[$];
  beat_t exp_q[$];
  beat_t rcv_q[$];
  beat_t pkt_q[$];
  int    rcv_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    drop_pulses;
  int    exp_drops;
  int    stab_errs;
  bit    timed_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_pack #(.AXIS_DW(DW), .USER_W(UW), .DROP_EMPTY(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep), .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .empty_drop(empty_drop), .busy(busy)
  );

  axis_pack #(.AXIS_DW(DW), .USER_W(UW), .DROP_EMPTY(1'b0)) u_keep (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(k_s_valid), .s_axis_tready(k_s_ready), .s_axis_tdata(k_s_data),
    .s_axis_tkeep(k_s_keep), .s_axis_tlast(k_s_last), .s_axis_tuser(k_s_user),
    .m_axis_tvalid(k_m_valid), .m_axis_tready(k_m_ready), .m_axis_tdata(k_m_data),
    .m_axis_tkeep(k_m_keep), .m_axis_tlast(k_m_last), .m_axis_tuser(k_m_user),
    .empty_drop(k_empty_drop), .busy(k_busy)
  );

  task automatic add_beat(input logic [KW-1:0] keep, input logic last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[32*w +: 32] = $urandom;
    b.keep = keep;
    b.last = last;
    b.user = UW'($urandom);
    pkt_q.push_back(b);
  endtask

  // Reference: collect the kept bytes of the packet in order, then cut into KW-byte beats
  task automatic model_packet();
    logic [7:0]    bq[$];
    logic [UW-1:0] u;
    beat_t         e;
    u = pkt_q[0].user;
    foreach (pkt_q[b]) begin
      for (int i = 0; i < KW; i++)
        if (pkt_q[b].keep[i]) bq.push_back(pkt_q[b].data[8*i +: 8]);
      in_q.push_back(pkt_q[b]);
    end
    if (bq.size() == 0) exp_drops++;
    while (bq.size() > 0) begin
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < KW; i++) begin
        if (bq.size() > 0) begin
          e.data[8*i +: 8] = bq.pop_front();
          e.keep[i] = 1'b1;
        end
      end
      e.last = (bq.size() == 0);
      e.user = u;
      exp_q.push_back(e);
    end
    pkt_q.delete();
  endtask

  task automatic stream(input int vpct, input int rpct);
    int    cyc;
    bit    held, fire_in, fire_out;
    beat_t hb, rb;
    cyc = 0; held = 0; drop_pulses = 0; stab_errs = 0; timed_out = 0;
    rcv_q.delete();
    rcv_cyc.delete();
    @(posedge clk); #1;
    while (1) begin
      if (in_q.size() > 0) begin
        s_valid = ($urandom_range(99) < vpct);
        s_data = in_q[0].data; s_keep = in_q[0].keep;
        s_last = in_q[0].last; s_user = in_q[0].user;
      end else begin
        s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_user = '0;
      end
      m_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (empty_drop) drop_pulses++;
      if (held && (m_valid !== 1'b1 || m_data !== hb.data || m_keep !== hb.keep ||
                   m_last !== hb.last || m_user !== hb.user)) stab_errs++;
      held = m_valid && !m_ready;
      hb.data = m_data; hb.keep = m_keep; hb.last = m_last; hb.user = m_user;
      fire_in  = s_valid && s_ready;
      fire_out = m_valid && m_ready;
      if (fire_out) begin
        rb = hb;
        rcv_q.push_back(rb);
        rcv_cyc.push_back(cyc);
      end
      if (!fire_in && in_q.size() == 0 && !busy && !m_valid) break;
      if (cyc > 30000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire_in) void'(in_q.pop_front());
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 0 || m_data !== '0 || m_keep !== '0 || m_last !== 0 || m_user !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%b d=%h k=%h l=%b u=%h want all 0",
               m_valid, m_data, m_keep, m_last, m_user);
    end
    checks++;
    if (s_ready !== 0 || empty_drop !== 0 || busy !== 0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got rdy=%b drop=%b busy=%b want 0 0 0", s_ready, empty_drop, busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge got %b want 0", s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge got %b want 1", s_ready);
    end
  endtask

  task automatic test_holes();
    add_beat(8'hF0, 0); add_beat(8'hFF, 0); add_beat(8'h0F, 1);
    model_packet();
    stream(100, 100);
    checks++;
    if (rcv_q.size() !== exp_q.size() || timed_out || stab_errs != 0) begin
      errors++;
      $display("[TB] FAIL holes_count got %0d beats (to=%0d stab=%0d) want %0d", rcv_q.size(), timed_out, stab_errs, exp_q.size());
    end
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rcv_q[i].data !== exp_q[i].data || rcv_q[i].keep !== exp_q[i].keep ||
          rcv_q[i].last !== exp_q[i].last || rcv_q[i].user !== exp_q[i].user) begin
        errors++;
        $display("[TB] FAIL holes_beat%0d got %h/%h/%b want %h/%h/%b", i, rcv_q[i].data, rcv_q[i].keep,
                 rcv_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_sparse();
    add_beat(8'hA5, 0); add_beat(8'h00, 0); add_beat(8'h3C, 1);
    model_packet();
    stream(50, 50);
    checks++;
    if (rcv_q.size() !== 1 || timed_out || stab_errs != 0) begin
      errors++;
      $display("[TB] FAIL sparse_count got %0d beats (to=%0d stab=%0d) want 1", rcv_q.size(), timed_out, stab_errs);
    end
    if (rcv_q.size() == 1 && exp_q.size() == 1) begin
      checks++;
      if (rcv_q[0].data !== exp_q[0].data || rcv_q[0].keep !== 8'hFF ||
          rcv_q[0].last !== 1'b1 || rcv_q[0].user !== exp_q[0].user) begin
        errors++;
        $display("[TB] FAIL sparse_beat got %h/%h/%b want %h/ff/1", rcv_q[0].data, rcv_q[0].keep,
                 rcv_q[0].last, exp_q[0].data);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_null_tail();
    for (int i = 0; i < 4; i++) add_beat(8'hFF, 0);
    add_beat(8'h00, 1);
    model_packet();
    stream(100, 50);
    checks++;
    if (rcv_q.size() !== 4 || timed_out || stab_errs != 0) begin
      errors++;
      $display("[TB] FAIL null_tail_count got %0d beats (to=%0d stab=%0d) want 4", rcv_q.size(), timed_out, stab_errs);
    end
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rcv_q[i].data !== exp_q[i].data || rcv_q[i].keep !== 8'hFF ||
          rcv_q[i].last !== (i == 3) || rcv_q[i].user !== exp_q[i].user) begin
        errors++;
        $display("[TB] FAIL null_tail_beat%0d got %h/%h/%b want %h/ff/%0d", i, rcv_q[i].data,
                 rcv_q[i].keep, rcv_q[i].last, exp_q[i].data, (i == 3));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_empty_drop();
    exp_drops = 0;
    add_beat(8'h00, 1);
    model_packet();
    add_beat(8'h00, 0); add_beat(8'h00, 1);
    model_packet();
    stream(100, 100);
    checks++;
    if (drop_pulses !== 2 || rcv_q.size() !== 0 || timed_out) begin
      errors++;
      $display("[TB] FAIL empty_drop got pulses=%0d beats=%0d to=%0d want pulses=2 beats=0",
               drop_pulses, rcv_q.size(), timed_out);
    end
  endtask

  task automatic test_empty_keep();
    int n;
    @(posedge clk); #1;
    k_s_valid = 1'b1; k_s_keep = '0; k_s_last = 1'b1;
    k_s_data = {$urandom, $urandom}; k_s_user = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!k_s_ready && n < 20);
    @(posedge clk); #1;
    k_s_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!k_m_valid && n < 20);
    checks++;
    if (k_m_valid !== 1'b1 || k_m_keep !== 8'h01 || k_m_data !== '0 ||
        k_m_last !== 1'b1 || k_m_user !== 2'b10) begin
      errors++;
      $display("[TB] FAIL empty_keep got v=%b k=%h d=%h l=%b u=%h want 1/01/0/1/2",
               k_m_valid, k_m_keep, k_m_data, k_m_last, k_m_user);
    end
    @(posedge clk); #1;
    k_m_ready = 1'b1;
    @(posedge clk); #1;
    k_m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (k_m_valid !== 1'b0 || k_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_keep_done got v=%b busy=%b want 0 0", k_m_valid, k_busy);
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 19; i++) add_beat(8'hFF, 0);
    add_beat(8'hFF, 1);
    model_packet();
    stream(100, 100);
    checks++;
    if (rcv_q.size() !== 20 || timed_out) begin
      errors++;
      $display("[TB] FAIL tput_count got %0d want 20", rcv_q.size());
    end else begin
      checks++;
      if (rcv_cyc[19] - rcv_cyc[0] !== 19) begin
        errors++;
        $display("[TB] FAIL tput_span got %0d cycles want 19", rcv_cyc[19] - rcv_cyc[0]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int nb, r, bad;
    logic [KW-1:0] k;
    exp_drops = 0;
    bad = 0;
    for (int p = 0; p < 200; p++) begin
      nb = $urandom_range(5, 1);
      for (int b = 0; b < nb; b++) begin
        r = $urandom_range(99);
        k = (r < 25) ? 8'hFF : (r < 45) ? 8'h00 : KW'($urandom);
        add_beat(k, b == nb - 1);
      end
      model_packet();
    end
    stream(50, 50);
    checks++;
    if (rcv_q.size() !== exp_q.size() || timed_out || stab_errs != 0) begin
      errors++;
      $display("[TB] FAIL rand_count got %0d beats (to=%0d stab=%0d) want %0d", rcv_q.size(), timed_out, stab_errs, exp_q.size());
    end
    checks++;
    if (drop_pulses !== exp_drops) begin
      errors++;
      $display("[TB] FAIL rand_drops got %0d want %0d", drop_pulses, exp_drops);
    end
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rcv_q[i].data !== exp_q[i].data || rcv_q[i].keep !== exp_q[i].keep ||
          rcv_q[i].last !== exp_q[i].last || rcv_q[i].user !== exp_q[i].user) begin
        errors++;
        if (bad++ < 10)
          $display("[TB] FAIL rand_beat%0d got %h/%h/%b/%h want %h/%h/%b/%h", i, rcv_q[i].data,
                   rcv_q[i].keep, rcv_q[i].last, rcv_q[i].user, exp_q[i].data, exp_q[i].keep,
                   exp_q[i].last, exp_q[i].user);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    s_valid = 1'b1; s_keep = 8'h1F; s_last = 1'b0; s_data = {$urandom, $urandom}; s_user = '1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy got %b want 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 0 || m_data !== '0 || m_keep !== '0 || m_last !== 0 ||
        s_ready !== 0 || busy !== 0 || m_user !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got v=%b d=%h k=%h l=%b rdy=%b busy=%b want all 0",
               m_valid, m_data, m_keep, m_last, s_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    add_beat(8'hFF, 0); add_beat(8'h3C, 1);
    model_packet();
    stream(100, 100);
    checks++;
    if (rcv_q.size() !== exp_q.size() || timed_out) begin
      errors++;
      $display("[TB] FAIL post_reset_count got %0d want %0d", rcv_q.size(), exp_q.size());
    end
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rcv_q[i].data !== exp_q[i].data || rcv_q[i].keep !== exp_q[i].keep ||
          rcv_q[i].last !== exp_q[i].last || rcv_q[i].user !== exp_q[i].user) begin
        errors++;
        $display("[TB] FAIL post_reset_beat%0d got %h/%h/%b want %h/%h/%b", i, rcv_q[i].data,
                 rcv_q[i].keep, rcv_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 0; s_data = '0; s_keep = '0; s_last = 0; s_user = '0; m_ready = 0;
    k_s_valid = 0; k_s_data = '0; k_s_keep = '0; k_s_last = 0; k_s_user = '0; k_m_ready = 0;
    exp_drops = 0;
    test_reset();
    test_holes();
    test_sparse();
    test_null_tail();
    test_empty_drop();
    test_empty_keep();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
